// File: rtl/load_store_unit.sv
// Sequences byte/word load-store requests onto a single-port byte-wide data memory,
// one memory access per cycle, little-endian, address wrapping modulo 2**A.
module load_store_unit #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           ReqValid,
    output logic           ReqReady,
    input  logic           ReqWrite,
    input  logic           ReqWide,
    input  logic [A-1:0]   ReqAddr,
    input  logic [2*W-1:0] ReqData,
    output logic           RespValid,
    input  logic           RespReady,
    output logic [2*W-1:0] RespData,
    output logic [A-1:0]   MemAddr,
    output logic           MemWrEn,
    output logic [W-1:0]   MemWrData,
    input  logic [W-1:0]   MemRdData
);

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, RESP} state_t;

    state_t         state;
    logic           lat_write;
    logic           lat_wide;
    logic [A-1:0]   lat_addr;
    logic [W-1:0]   lat_hi;

    // Mem* outputs are set up on the edge entering each byte state, so they depend on state only.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            ReqReady  <= 1'b0;
            RespValid <= 1'b0;
            RespData  <= '0;
            MemAddr   <= '0;
            MemWrEn   <= 1'b0;
            MemWrData <= '0;
            lat_write <= 1'b0;
            lat_wide  <= 1'b0;
            lat_addr  <= '0;
            lat_hi    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid && ReqReady) begin
                        state     <= BYTE0;
                        ReqReady  <= 1'b0;
                        RespData  <= '0;
                        lat_write <= ReqWrite;
                        lat_wide  <= ReqWide;
                        lat_addr  <= ReqAddr;
                        lat_hi    <= ReqData[2*W-1:W];
                        MemAddr   <= ReqAddr;
                        MemWrEn   <= ReqWrite;
                        MemWrData <= ReqData[W-1:0];
                    end else begin
                        ReqReady  <= 1'b1;
                    end
                end
                BYTE0: begin
                    if (!lat_write)
                        RespData[W-1:0] <= MemRdData;
                    if (lat_wide) begin
                        state     <= BYTE1;
                        MemAddr   <= lat_addr + A'(1);
                        MemWrEn   <= lat_write;
                        MemWrData <= lat_hi;
                    end else begin
                        state     <= RESP;
                        MemWrEn   <= 1'b0;
                        RespValid <= 1'b1;
                    end
                end
                BYTE1: begin
                    if (!lat_write)
                        RespData[2*W-1:W] <= MemRdData;
                    state     <= RESP;
                    MemWrEn   <= 1'b0;
                    RespValid <= 1'b1;
                end
                RESP: begin
                    if (RespReady) begin
                        state     <= IDLE;
                        RespValid <= 1'b0;
                        RespData  <= '0;
                        ReqReady  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed scenarios plus random transactions against a byte-array memory model.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid, ReqReady, ReqWrite, ReqWide;
    logic [7:0]  ReqAddr;
    logic [15:0] ReqData;
    logic        RespValid, RespReady;
    logic [15:0] RespData;
    logic [7:0]  MemAddr;
    logic        MemWrEn;
    logic [7:0]  MemWrData;
    logic [7:0]  MemRdData;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    int          n_checks = 0;
    int          n_errors = 0;

    load_store_unit #(.W(8), .A(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqWide(ReqWide),
        .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
        .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData), .MemRdData(MemRdData)
    );

    always #5 Clk = ~Clk;

    assign MemRdData = mem[MemAddr];
    always @(posedge Clk) if (MemWrEn) mem[MemAddr] <= MemWrData;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic txn(input logic wr, input logic wide, input logic [7:0] addr,
                       input logic [15:0] data, input int hold);
        logic [7:0]  a1;
        logic [15:0] exp, held;
        int n, we;
        a1 = addr + 8'd1;
        n = 0;
        while (!ReqReady && n < 20) begin @(posedge Clk); #1; n++; end
        check("req_ready", 32'(ReqReady), 1);
        ReqValid = 1'b1; ReqWrite = wr; ReqWide = wide; ReqAddr = addr; ReqData = data;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        if (wr) begin
            ref_mem[addr] = data[7:0];
            if (wide) ref_mem[a1] = data[15:8];
            exp = 16'h0000;
        end else begin
            exp = wide ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
        end
        n = 0; we = 0;
        while (!RespValid && n < 10) begin
            check("busy_ready", 32'(ReqReady), 0);
            check("mem_addr", 32'(MemAddr), (n == 0) ? 32'(addr) : 32'(a1));
            if (MemWrEn) we++;
            @(posedge Clk); #1; n++;
        end
        check("latency", n, wide ? 2 : 1);
        check("wr_pulses", we, wr ? (wide ? 2 : 1) : 0);
        check("resp_data", 32'(RespData), 32'(exp));
        check("resp_wren", 32'(MemWrEn), 0);
        held = RespData;
        for (int i = 0; i < hold; i++) begin
            ReqValid = 1'b1; ReqWrite = 1'b1; ReqWide = 1'b1; ReqAddr = addr; ReqData = ~data;
            @(posedge Clk); #1;
            check("hold_valid", 32'(RespValid), 1);
            check("hold_data", 32'(RespData), 32'(held));
            check("hold_ready", 32'(ReqReady), 0);
            check("hold_wren", 32'(MemWrEn), 0);
        end
        ReqValid = 1'b0;
        RespReady = 1'b1;
        @(posedge Clk); #1;
        RespReady = 1'b0;
        check("resp_done", 32'(RespValid), 0);
        check("ready_back", 32'(ReqReady), 1);
        check("mem_lo", 32'(mem[addr]), 32'(ref_mem[addr]));
        check("mem_hi", 32'(mem[a1]), 32'(ref_mem[a1]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, overlap;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom);
            mem[i] = a;
            ref_mem[i] = a;
        end
        Reset = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqWide = 1'b0;
        ReqAddr = '0; ReqData = '0; RespReady = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ready", 32'(ReqReady), 0);
        check("rst_rvalid", 32'(RespValid), 0);
        check("rst_rdata", 32'(RespData), 0);
        check("rst_wren", 32'(MemWrEn), 0);
        check("rst_addr", 32'(MemAddr), 0);
        check("rst_wdata", 32'(MemWrData), 0);
        @(negedge Clk); Reset = 1'b1;
        #1 check("rel_ready_low", 32'(ReqReady), 0);
        @(posedge Clk); #1;
        check("rel_ready_high", 32'(ReqReady), 1);

        // directed: byte, word, wrap, held response
        txn(1'b1, 1'b0, 8'h10, 16'h00A5, 0);
        txn(1'b0, 1'b0, 8'h10, 16'h0000, 0);
        check("byte_load_val", 32'(ref_mem[8'h10]), 32'h00A5);
        txn(1'b1, 1'b1, 8'h20, 16'hBEEF, 0);
        txn(1'b0, 1'b1, 8'h20, 16'h0000, 0);
        check("word_mem20", 32'(mem[8'h20]), 32'hEF);
        check("word_mem21", 32'(mem[8'h21]), 32'hBE);
        txn(1'b1, 1'b1, 8'hFF, 16'h1234, 0);
        check("wrap_memff", 32'(mem[8'hFF]), 32'h34);
        check("wrap_mem00", 32'(mem[8'h00]), 32'h12);
        txn(1'b0, 1'b1, 8'hFF, 16'h0000, 0);
        txn(1'b0, 1'b1, 8'h20, 16'h0000, 5);
        check("hold_no_accept", 32'(mem[8'h20]), 32'hEF);

        // reset during the high byte of a word store
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqWide = 1'b1; ReqAddr = 8'h40; ReqData = 16'hCAFE;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        check("abort_b0_wren", 32'(MemWrEn), 1);
        @(posedge Clk); #1;
        check("abort_b1_addr", 32'(MemAddr), 32'h41);
        check("abort_b1_wren", 32'(MemWrEn), 1);
        ref_mem[8'h40] = 8'hFE;
        Reset = 1'b0;
        #1;
        check("abort_wren", 32'(MemWrEn), 0);
        check("abort_ready", 32'(ReqReady), 0);
        check("abort_rvalid", 32'(RespValid), 0);
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1;
        check("abort_ready_back", 32'(ReqReady), 1);
        check("abort_mem40", 32'(mem[8'h40]), 32'hFE);
        check("abort_mem41", 32'(mem[8'h41]), 32'(ref_mem[8'h41]));

        // ReqValid and RespReady held high: one byte load every 3 cycles, never overlapping
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqWide = 1'b0; ReqAddr = 8'h10; ReqData = 16'h0;
        RespReady = 1'b1;
        hs = 0; overlap = 0;
        for (int i = 0; i < 12; i++) begin
            if (ReqValid && ReqReady) hs++;
            if (ReqReady && (RespValid || MemWrEn)) overlap++;
            if (RespValid) check("b2b_data", 32'(RespData), {24'h0, ref_mem[8'h10]});
            @(posedge Clk); #1;
        end
        ReqValid = 1'b0; RespReady = 1'b0;
        check("b2b_accepts", hs, 4);
        check("b2b_overlap", overlap, 0);

        for (int t = 0; t < 60; t++)
            txn(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        for (int i = 0; i < 256; i++)
            check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
